processor_stim_driver: RTL and testbench

Stimulus initiator for the two-input registered-AND processor block. It drives the operand pair `entrada_a`/`entrada_b` through all four input combinations for a programmable number of rounds. For each combination it samples the processor's registered `saida_a` return and counts mismatches against the expected `a & b`. It sits beside the processor as the driving and checking end of the same pin-level interface, for on-board self-test.

---
 rtl/processor_stim_driver.sv | 87 ++++++++
 tb/tb_processor_stim_driver.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/processor_stim_driver.sv
// processor_stim_driver: drives all four AND operand pairs for N rounds and counts registered-response mismatches.
module processor_stim_driver #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] rounds_i,
  input  logic             resp_i,
  output logic             entrada_a_o,
  output logic             entrada_b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic             pass_o
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state, state_next;
  logic [HW-1:0] h;
  logic [1:0] p, p_next;
  logic [CNT_W-1:0] rnd, rounds, err_next;
  logic chk, last, miss;
  // busy stays high through the first DONE cycle of a zero-round run, delaying done by one edge
  assign done_o = state == DONE && !busy_o;
  always_comb begin
    chk = state == DRIVE && h == HW'(HOLD_CYCLES - 1);
    last = chk && p == 2'd3 && rnd == rounds - 1'b1;
    miss = chk && resp_i != (entrada_a_o & entrada_b_o);
    err_next = miss && !(&err_count_o) ? err_count_o + 1'b1 : err_count_o;
    p_next = p + 2'd1;
    state_next = state == IDLE ? (start_i ? (rounds_i == '0 ? DONE : DRIVE) : IDLE) :
                 state == DRIVE ? (last ? DONE : DRIVE) :
                 (busy_o ? DONE : IDLE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      h <= '0;
      p <= '0;
      rnd <= '0;
      rounds <= '0;
      entrada_a_o <= 1'b0;
      entrada_b_o <= 1'b0;
      busy_o <= 1'b0;
      err_count_o <= '0;
      pass_o <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          entrada_a_o <= 1'b0;
          entrada_b_o <= 1'b0;
          if (start_i) begin
            rounds <= rounds_i;
            err_count_o <= '0;
            pass_o <= 1'b0;
            busy_o <= 1'b1;
            h <= '0;
            p <= '0;
            rnd <= '0;
          end
        end
        DRIVE: begin
          err_count_o <= err_next;
          if (chk) begin
            h <= '0;
            p <= p_next;
            if (p == 2'd3) rnd <= rnd + 1'b1;
            entrada_a_o <= last ? 1'b0 : p_next[1];
            entrada_b_o <= last ? 1'b0 : p_next[0];
            if (last) begin
              busy_o <= 1'b0;
              pass_o <= err_next == '0;
            end
          end else h <= h + 1'b1;
        end
        DONE: if (busy_o) begin
          busy_o <= 1'b0;
          pass_o <= err_count_o == '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_processor_stim_driver.sv
// tb_processor_stim_driver: directed checks of the stimulus driver against a registered-AND processor model.
module tb_processor_stim_driver;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [7:0] rounds = '0;
  logic a, b, busy, done, pass, proc_q = 1'b0;
  logic [7:0] err;
  int mode = 0, n_checks = 0, n_fail = 0;
  logic resp;
  always #5 clk = ~clk;
  always @(posedge clk) proc_q <= a & b;
  assign resp = mode == 0 ? proc_q : mode == 1 ? 1'b1 : ~proc_q;
  processor_stim_driver #(.HOLD_CYCLES(2), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rounds_i(rounds), .resp_i(resp),
    .entrada_a_o(a), .entrada_b_o(b), .busy_o(busy), .done_o(done),
    .err_count_o(err), .pass_o(pass)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [7:0] r, input int m);
    rounds = r;
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(output int busy_cycles);
    int g = 0;
    busy_cycles = 0;
    while (!done && g < 2000) begin
      if (busy) busy_cycles++;
      g++;
      tick();
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask
  initial begin
    int bc;
    logic saw;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {24'd0, err}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_ops", {30'd0, a, b}, 32'd0);
    go(8'd1, 0);
    check("r1_busy", {31'd0, busy}, 32'd1);
    check("r1_op0", {30'd0, a, b}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      tick();
      check("r1_op", {30'd0, a, b}, k);
    end
    tick();
    check("r1_nodone", {31'd0, done}, 32'd0);
    tick();
    check("r1_done", {31'd0, done}, 32'd1);
    check("r1_busy_end", {31'd0, busy}, 32'd0);
    check("r1_ops_end", {30'd0, a, b}, 32'd0);
    check("r1_err", {24'd0, err}, 32'd0);
    check("r1_pass", {31'd0, pass}, 32'd1);
    tick();
    check("r1_pulse", {31'd0, done}, 32'd0);
    go(8'd3, 1);
    wait_done(bc);
    check("r3_busy_cycles", bc, 32'd24);
    check("r3_err", {24'd0, err}, 32'd9);
    check("r3_pass", {31'd0, pass}, 32'd0);
    tick();
    go(8'd100, 2);
    wait_done(bc);
    check("r100_err_sat", {24'd0, err}, 32'd255);
    check("r100_pass", {31'd0, pass}, 32'd0);
    tick();
    tick();
    check("r100_hold_err", {24'd0, err}, 32'd255);
    check("r100_hold_pass", {31'd0, pass}, 32'd0);
    go(8'd0, 0);
    check("r0_busy", {31'd0, busy}, 32'd1);
    check("r0_nodone", {31'd0, done}, 32'd0);
    check("r0_err_clr", {24'd0, err}, 32'd0);
    check("r0_ops", {30'd0, a, b}, 32'd0);
    tick();
    check("r0_done", {31'd0, done}, 32'd1);
    check("r0_busy_end", {31'd0, busy}, 32'd0);
    check("r0_pass", {31'd0, pass}, 32'd1);
    check("r0_ops_end", {30'd0, a, b}, 32'd0);
    tick();
    check("r0_pulse", {31'd0, done}, 32'd0);
    go(8'd4, 0);
    tick();
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("r4_restart_op", {30'd0, a, b}, 32'd2);
    tick();
    tick();
    check("r4_op6", {30'd0, a, b}, 32'd3);
    tick();
    tick();
    tick();
    tick();
    check("r4_op10", {30'd0, a, b}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ops", {30'd0, a, b}, 32'd0);
    check("abort_pass", {31'd0, pass}, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw |= done | busy;
      tick();
    end
    check("abort_no_done", {31'd0, saw}, 32'd0);
    rst = 1'b1;
    start = 1'b1;
    rounds = 8'd1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_wins", {31'd0, busy}, 32'd0);
    go(8'd1, 0);
    wait_done(bc);
    check("fresh_busy_cycles", bc, 32'd8);
    check("fresh_err", {24'd0, err}, 32'd0);
    check("fresh_pass", {31'd0, pass}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
